// File: rtl/alu_pkg.sv
// alu_pkg: shared types and tables for alu_pipe.
//   funcode_e    arithmetic op select (add/sub/cmp/mov)
//   kernelsel_e  3x3 kernel select (identity/gaussian/sharpen/edge)
//   CPSR_*       bit positions of {N,Z,C,V} in cpsr
//   kcoef()      signed coefficient for a kernel tap (0..8, row-major)
//   kshift()     arithmetic right shift applied after accumulation
package alu_pkg;

   typedef enum logic [1:0] {
      FN_ADD = 2'b00,
      FN_SUB = 2'b01,
      FN_CMP = 2'b10,
      FN_MOV = 2'b11
   } funcode_e;

   typedef enum logic [1:0] {
      K_IDENT = 2'b00,
      K_GAUSS = 2'b01,
      K_SHARP = 2'b10,
      K_EDGE  = 2'b11
   } kernelsel_e;

   localparam logic [1:0] FT_KERNEL = 2'b11;

   localparam int CPSR_N = 3;
   localparam int CPSR_Z = 2;
   localparam int CPSR_C = 1;
   localparam int CPSR_V = 0;

   // All four kernels are symmetric, so a tap is fully described by
   // whether it is the center, a corner or an edge-adjacent position.
   function automatic logic signed [4:0] kcoef(input logic [1:0] ksel, input logic [3:0] tap);
      logic center, corner;
      center = (tap == 4'd4);
      corner = (tap == 4'd0) || (tap == 4'd2) || (tap == 4'd6) || (tap == 4'd8);
      case (ksel)
         K_IDENT: kcoef = center ? 5'sd1 : 5'sd0;
         K_GAUSS: kcoef = center ? 5'sd4 : (corner ? 5'sd1 : 5'sd2);
         K_SHARP: kcoef = center ? 5'sd5 : (corner ? 5'sd0 : -5'sd1);
         default: kcoef = center ? 5'sd8 : -5'sd1;
      endcase
   endfunction

   // Only the gaussian needs normalising (coefficients sum to 16).
   function automatic logic [2:0] kshift(input logic [1:0] ksel);
      kshift = (ksel == K_GAUSS) ? 3'd4 : 3'd0;
   endfunction

endpackage

// File: rtl/kernel_conv3x3.sv
// kernel_conv3x3: sequential 3x3 convolution, one multiply-add per cycle.
//   clk, rst_n   clock / async active-low reset (aborts any operation)
//   start        pulse in IDLE: latch kernelsel + window, clear accumulator
//   kernelsel    kernel select (alu_pkg::kernelsel_e)
//   window       window[r], pixel c at bits [(3-c)*PIX-1 -: PIX]
//   busy         high while in MAC or SCALE
//   done         one-cycle pulse in SCALE; kres/kclamp valid with it
//   kres         scaled, clamped result in [0, 2^PIX-1]
//   kclamp       clamp was applied at either bound
// Only compiled into kernel-enabled builds (macro ALU_KERNEL_EN).
`ifdef ALU_KERNEL_EN
module kernel_conv3x3
   import alu_pkg::*;
#(
   parameter int PIX   = 8,
   parameter int ACC_W = PIX + 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [1:0]                kernelsel,
   input  logic [2:0][3*PIX-1:0]     window,
   output logic                      busy,
   output logic                      done,
   output logic [PIX-1:0]            kres,
   output logic                      kclamp
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MAC   = 2'd1;
   localparam logic [1:0] ST_SCALE = 2'd2;

   localparam logic signed [ACC_W-1:0] PMAX = ACC_W'((2 ** PIX) - 1);

   logic [1:0]              state;
   logic [3:0]              tap;
   logic [1:0]              ksel_q;
   logic [2:0][3*PIX-1:0]   win_q;
   logic signed [ACC_W-1:0] acc;

   logic [8:0][PIX-1:0]     taps;
   logic signed [ACC_W-1:0] pxs, cfs, prod, sh;

   // Flatten the window into row-major tap order.
   always_comb begin
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            taps[r*3+c] = win_q[r][(3-c)*PIX-1 -: PIX];
   end

   // Pixel is unsigned, coefficient signed; both widened to ACC_W so the
   // product is exact.
   always_comb begin
      pxs  = signed'(ACC_W'(taps[tap]));
      cfs  = ACC_W'(kcoef(ksel_q, tap));
      prod = pxs * cfs;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         tap    <= '0;
         ksel_q <= '0;
         win_q  <= '0;
         acc    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               ksel_q <= kernelsel;
               win_q  <= window;
               acc    <= '0;
               tap    <= '0;
               state  <= ST_MAC;
            end
            ST_MAC: begin
               acc <= acc + prod;
               if (tap == 4'd8) state <= ST_SCALE;
               else             tap   <= tap + 4'd1;
            end
            ST_SCALE: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_SCALE);

   always_comb begin
      sh = acc >>> kshift(ksel_q);
      if (sh[ACC_W-1]) begin
         kres   = '0;
         kclamp = 1'b1;
      end else if (sh > PMAX) begin
         kres   = '1;
         kclamp = 1'b1;
      end else begin
         kres   = sh[PIX-1:0];
         kclamp = 1'b0;
      end
   end

endmodule
`endif

// File: rtl/alu_pipe.sv
// alu_pipe: clocked, handshaked execute-stage ALU.
//   clk, rst_n            clock / async active-low reset
//   in_valid, in_ready    operation handshake (in_ready stalls upstream)
//   funtype               2'b11 kernel op, else arithmetic
//   funcode               00 add, 01 sub, 10 cmp, 11 mov
//   kernelsel             00 identity, 01 gaussian, 10 sharpen, 11 edge
//   opa, opb              operands (mov passes opb)
//   window                3x3 pixel window for kernel ops
//   out_valid, out_ready  result handshake (out_ready = writeback takes it)
//   result, result_we     result and its write enable (0 for cmp)
//   cpsr                  {N,Z,C,V} of the op
// Build option ALU_KERNEL_EN: enables the multi-cycle 3x3 convolution.
// Without it a kernel op completes in one cycle with result 0, no write,
// and cpsr 4'b0101 (V marks the op as unsupported).
module alu_pipe
   import alu_pkg::*;
#(
   parameter int BUS   = 8,
   parameter int PIX   = 8,
   parameter int ACC_W = PIX + 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            funtype,
   input  logic [1:0]            funcode,
   input  logic [1:0]            kernelsel,
   input  logic [BUS-1:0]        opa,
   input  logic [BUS-1:0]        opb,
   input  logic [2:0][3*PIX-1:0] window,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BUS-1:0]        result,
   output logic                  result_we,
   output logic [3:0]            cpsr
);

   logic accept, is_kern, busy;

   // A new op may enter in the same cycle the held result is consumed.
   assign in_ready = ~busy & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;
   assign is_kern  = (funtype == FT_KERNEL);

   // Single adder: sub/cmp as opa + ~opb + 1, mov as 0 + opb.
   logic [BUS-1:0] a_eff, b_eff, ar_res;
   logic           cin, ar_c, ar_v;

   always_comb begin
      a_eff = opa;
      b_eff = opb;
      cin   = 1'b0;
      case (funcode)
         FN_SUB, FN_CMP: begin
            b_eff = ~opb;
            cin   = 1'b1;
         end
         FN_MOV:  a_eff = '0;
         default: ;
      endcase
      {ar_c, ar_res} = {1'b0, a_eff} + {1'b0, b_eff} + (BUS+1)'(cin);
      ar_v = (a_eff[BUS-1] == b_eff[BUS-1]) && (ar_res[BUS-1] != a_eff[BUS-1]);
   end

`ifdef ALU_KERNEL_EN
   logic           k_done, k_clamp;
   logic [PIX-1:0] k_res;

   kernel_conv3x3 #(.PIX(PIX), .ACC_W(ACC_W)) u_kern (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (accept & is_kern),
      .kernelsel (kernelsel),
      .window    (window),
      .busy      (busy),
      .done      (k_done),
      .kres      (k_res),
      .kclamp    (k_clamp)
   );
`else
   logic unused_inputs;
   assign unused_inputs = ^{window, kernelsel};
   assign busy          = 1'b0;
`endif

   // Next value for the output register; ld marks a new result this edge.
   logic           ld, ld_we;
   logic [BUS-1:0] ld_res;
   logic [3:0]     ld_cpsr;

   always_comb begin
      ld      = 1'b0;
      ld_res  = ar_res;
      ld_we   = (funcode != FN_CMP);
      ld_cpsr = {ar_res[BUS-1], ar_res == '0, ar_c, ar_v};
      if (accept && !is_kern) begin
         ld = 1'b1;
      end
`ifdef ALU_KERNEL_EN
      else if (k_done) begin
         ld      = 1'b1;
         ld_res  = BUS'(k_res);
         ld_we   = 1'b1;
         ld_cpsr = {1'b0, k_res == '0, 1'b0, k_clamp};
      end
`else
      else if (accept) begin
         ld      = 1'b1;
         ld_res  = '0;
         ld_we   = 1'b0;
         ld_cpsr = 4'b0101;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         result_we <= 1'b0;
         cpsr      <= '0;
      end else if (ld) begin
         out_valid <= 1'b1;
         result    <= ld_res;
         result_we <= ld_we;
         cpsr      <= ld_cpsr;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
